// File: rtl/data_sram_bridge_pkg.sv
// Shared types for the MEM-stage data bridge: FSM state codes, bus size codes
// and the byte-enable decoder used to classify each access.
package data_sram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [1:0] size;
  } sel_dec_t;

  // A zero mask is a full-word read; irregular masks are flagged invalid and never issued.
  function automatic sel_dec_t decode_sel(input logic [3:0] sel);
    sel_dec_t d;
    d.valid = 1'b1;
    d.wr    = 1'b1;
    d.size  = SIZE_BYTE;
    case (sel)
      4'b0000: begin
        d.wr   = 1'b0;
        d.size = SIZE_WORD;
      end
      4'b0001, 4'b0010, 4'b0100, 4'b1000: d.size = SIZE_BYTE;
      4'b0011, 4'b1100:                   d.size = SIZE_HALF;
      4'b1111:                            d.size = SIZE_WORD;
      default: begin
        d.valid = 1'b0;
        d.wr    = 1'b0;
        d.size  = SIZE_BYTE;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/data_sram_bridge.sv
// MEM-stage bridge onto the SRAM-like data bus: one outstanding access,
// pipeline stall while in flight, read word held until the pipeline advances.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              flush,
  input  logic              pipe_adv,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_e            state_q, state_d;
  logic              req_wr_q, req_wr_d;
  logic [1:0]        req_size_q, req_size_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cancel_q, cancel_d;

  sel_dec_t sel_dec;
  logic     start;
  logic     xfer_done;
  logic     cancel_now;

  assign sel_dec    = decode_sel(mem_sel);
  assign start      = mem_en & ~flush & sel_dec.valid;
  assign xfer_done  = ((state_q == ST_REQ) & data_addr_ok & data_data_ok)
                    | ((state_q == ST_WAIT) & data_data_ok);
  assign cancel_now = cancel_q | flush;

  // State and request/result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_wr_q    <= 1'b0;
      req_size_q  <= 2'd0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      cancel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_wr_q    <= req_wr_d;
      req_size_q  <= req_size_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
      cancel_q    <= cancel_d;
    end
  end

  // Next-state logic; a cancelled access drains on the bus and then skips DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
        else       state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (data_addr_ok && data_data_ok) state_d = cancel_now ? ST_IDLE : ST_DONE;
        else if (data_addr_ok)            state_d = ST_WAIT;
        else                              state_d = ST_REQ;
      end
      ST_WAIT: begin
        if (data_data_ok) state_d = cancel_now ? ST_IDLE : ST_DONE;
        else              state_d = ST_WAIT;
      end
      ST_DONE: begin
        if (pipe_adv || flush) state_d = ST_IDLE;
        else                   state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch on acceptance, read capture, and cancel tracking.
  always_comb begin
    req_wr_d    = req_wr_q;
    req_size_d  = req_size_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    cancel_d    = 1'b0;
    if ((state_q == ST_IDLE) && start) begin
      req_wr_d    = sel_dec.wr;
      req_size_d  = sel_dec.size;
      req_addr_d  = sel_dec.wr ? mem_addr : {mem_addr[ADDR_W-1:2], 2'b00};
      req_wdata_d = mem_wdata;
    end else begin
      req_wr_d = req_wr_q;
    end
    if (xfer_done && !req_wr_q && !cancel_now) begin
      rdata_d = data_rdata;
    end else begin
      rdata_d = rdata_q;
    end
    if ((state_d == ST_REQ) || (state_d == ST_WAIT)) begin
      cancel_d = cancel_now;
    end else begin
      cancel_d = 1'b0;
    end
  end

  // Bus outputs come straight from registers; only stall sees live inputs.
  always_comb begin
    data_req   = (state_q == ST_REQ);
    data_wr    = req_wr_q;
    data_size  = req_size_q;
    data_addr  = req_addr_q;
    data_wdata = req_wdata_q;
    mem_rdata  = rdata_q;
    stall      = ((state_q == ST_IDLE) & start) | (state_q == ST_REQ) | (state_q == ST_WAIT);
  end

endmodule
